cpu_core: RTL and testbench

- Multicycle 32-bit word-addressed RISC core, ECE350-style ISA, no multiply/divide.
- Drives an external synchronous instruction ROM, a 32x32 register file and a synchronous data RAM.
- Sits at the top of the system between the instruction memory, register file and data memory.
- Each instruction takes 2 cycles (FETCH, EXEC); lw takes 3 (FETCH, EXEC, MEM).

---
 rtl/cpu_core.sv | 164 ++++++++++++++++
 tb/tb_cpu_core.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Multicycle 32-bit word-addressed RISC core: FETCH/EXEC for most instructions, plus MEM for lw.
// Talks to an external synchronous ROM, a combinational-read register file and a synchronous RAM.
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  localparam logic [4:0] OpR    = 5'b00000;
  localparam logic [4:0] OpJ    = 5'b00001;
  localparam logic [4:0] OpBne  = 5'b00010;
  localparam logic [4:0] OpJal  = 5'b00011;
  localparam logic [4:0] OpJr   = 5'b00100;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpBlt  = 5'b00110;
  localparam logic [4:0] OpSw   = 5'b00111;
  localparam logic [4:0] OpLw   = 5'b01000;
  localparam logic [4:0] OpSetx = 5'b10101;
  localparam logic [4:0] OpBex  = 5'b10110;

  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
  localparam logic [4:0] AluAnd = 5'b00010;
  localparam logic [4:0] AluOr  = 5'b00011;
  localparam logic [4:0] AluSll = 5'b00100;
  localparam logic [4:0] AluSra = 5'b00101;

  typedef enum logic [1:0] {StFetch, StExec, StMem} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic [4:0]  op, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_sext, t_zext, a, b, pc_inc;
  logic [31:0] sum_ab, diff_ab, sum_ai;
  logic        ovf_add, ovf_sub, ovf_addi;
  logic        wr_en;

  // The ROM re-registers the same PC while lw sits in MEM, so q_imem stays decodable there.
  assign op       = q_imem[31:27];
  assign rd       = q_imem[26:22];
  assign rs       = q_imem[21:17];
  assign rt       = q_imem[16:12];
  assign shamt    = q_imem[11:7];
  assign aluop    = q_imem[6:2];
  assign imm_sext = {{15{q_imem[16]}}, q_imem[16:0]};
  assign t_zext   = {5'b0, q_imem[26:0]};

  assign a      = data_readRegA;
  assign b      = data_readRegB;
  assign pc_inc = pc_q + 32'd1;

  assign sum_ab  = a + b;
  assign diff_ab = a - b;
  assign sum_ai  = a + imm_sext;

  // Signed overflow: result sign disagrees with the sign both effective operands share.
  assign ovf_add  = (a[31] == b[31]) && (sum_ab[31] != a[31]);
  assign ovf_sub  = (a[31] != b[31]) && (diff_ab[31] != a[31]);
  assign ovf_addi = (a[31] == imm_sext[31]) && (sum_ai[31] != a[31]);

  assign address_imem  = pc_q;
  assign ctrl_readRegA = (op == OpBex) ? 5'd30 : rs;
  assign ctrl_readRegB = (op == OpR) ? rt : rd;
  assign address_dmem  = sum_ai;
  assign data          = b;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wr_en         = 1'b0;
    ctrl_writeReg = rd;
    data_writeReg = '0;
    wren          = 1'b0;
    unique case (state_q)
      StFetch: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        case (op)
          OpR: begin
            case (aluop)
              AluAdd: begin
                wr_en         = 1'b1;
                data_writeReg = ovf_add ? 32'd1 : sum_ab;
                if (ovf_add) ctrl_writeReg = 5'd30;
              end
              AluSub: begin
                wr_en         = 1'b1;
                data_writeReg = ovf_sub ? 32'd3 : diff_ab;
                if (ovf_sub) ctrl_writeReg = 5'd30;
              end
              AluAnd: begin wr_en = 1'b1; data_writeReg = a & b; end
              AluOr:  begin wr_en = 1'b1; data_writeReg = a | b; end
              AluSll: begin wr_en = 1'b1; data_writeReg = a << shamt; end
              AluSra: begin wr_en = 1'b1; data_writeReg = $signed(a) >>> shamt; end
              default: ;
            endcase
          end
          OpAddi: begin
            wr_en         = 1'b1;
            data_writeReg = ovf_addi ? 32'd2 : sum_ai;
            if (ovf_addi) ctrl_writeReg = 5'd30;
          end
          OpSw: wren = 1'b1;
          OpLw: begin
            state_d = StMem;
            pc_d    = pc_q;
          end
          OpJ: pc_d = t_zext;
          OpJal: begin
            wr_en         = 1'b1;
            ctrl_writeReg = 5'd31;
            data_writeReg = pc_inc;
            pc_d          = t_zext;
          end
          OpJr:  pc_d = b;
          OpBne: if (b != a) pc_d = pc_inc + imm_sext;
          OpBlt: if ($signed(b) < $signed(a)) pc_d = pc_inc + imm_sext;
          OpSetx: begin
            wr_en         = 1'b1;
            ctrl_writeReg = 5'd30;
            data_writeReg = t_zext;
          end
          OpBex: if (a != 32'd0) pc_d = t_zext;
          default: ;
        endcase
      end
      StMem: begin
        wr_en         = 1'b1;
        data_writeReg = q_dmem;
        pc_d          = pc_inc;
        state_d       = StFetch;
      end
      default: state_d = StFetch;
    endcase
    ctrl_writeEnable = wr_en && (ctrl_writeReg != 5'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: bench-owned ROM/regfile/RAM plus an instruction-level reference model
// that predicts every cycle's address and write activity.
module tb_cpu_core;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  always #5 clock = ~clock;

  cpu_core #(.RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA),
    .data_readRegB(data_readRegB), .wren(wren), .address_dmem(address_dmem),
    .data(data), .q_dmem(q_dmem)
  );

  logic [31:0] rom     [64];
  logic [31:0] hw_regs [32];
  logic [31:0] ram     [4096];
  logic [31:0] ref_regs[32];
  logic [31:0] ref_mem [4096];
  logic [31:0] ref_pc;
  logic        load_en = 1'b0;

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : hw_regs[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : hw_regs[ctrl_readRegB];

  always @(posedge clock) begin
    q_imem <= rom[address_imem[5:0]];
    q_dmem <= ram[address_dmem[11:0]];
    if (load_en) begin
      for (int i = 0; i < 32; i++) hw_regs[i] <= ref_regs[i];
      for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
    end else begin
      if (ctrl_writeEnable) hw_regs[ctrl_writeReg] <= data_writeReg;
      if (wren) ram[address_dmem[11:0]] <= data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected activity of the instruction being modelled.
  logic        e_lw, e_we, e_wren;
  logic [4:0]  e_wr;
  logic [31:0] e_wd, e_mdata;
  logic [11:0] e_maddr;

  task automatic put(input logic [4:0] r, input logic [31:0] v);
    e_we = (r != 5'd0);
    e_wr = r;
    e_wd = v;
  endtask

  function automatic bit ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model_step();
    logic [31:0] ins, a, vrd, vrt, imm, t, npc, nxt, ea;
    logic [4:0]  op, rd, rs, rt, sh, fn;
    longint      s;
    ins = rom[ref_pc[5:0]];
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    sh = ins[11:7];  fn = ins[6:2];
    a = ref_regs[rs]; vrd = ref_regs[rd]; vrt = ref_regs[rt];
    imm = {{15{ins[16]}}, ins[16:0]};
    t = {5'b0, ins[26:0]};
    ea = a + imm;
    npc = ref_pc + 32'd1;
    nxt = npc;
    e_lw = 0; e_we = 0; e_wr = 0; e_wd = 0; e_wren = 0; e_maddr = 0; e_mdata = 0;
    case (op)
      5'd0: case (fn)
        5'd0: begin
          s = longint'($signed(a)) + longint'($signed(vrt));
          if (ovf(s)) put(5'd30, 32'd1); else put(rd, a + vrt);
        end
        5'd1: begin
          s = longint'($signed(a)) - longint'($signed(vrt));
          if (ovf(s)) put(5'd30, 32'd3); else put(rd, a - vrt);
        end
        5'd2: put(rd, a & vrt);
        5'd3: put(rd, a | vrt);
        5'd4: put(rd, a << sh);
        5'd5: put(rd, $signed(a) >>> sh);
        default: ;
      endcase
      5'd5: begin
        s = longint'($signed(a)) + longint'($signed(imm));
        if (ovf(s)) put(5'd30, 32'd2); else put(rd, ea);
      end
      5'd7: begin
        e_wren = 1; e_maddr = ea[11:0]; e_mdata = vrd;
        ref_mem[ea[11:0]] = vrd;
      end
      5'd8: begin e_lw = 1; put(rd, ref_mem[ea[11:0]]); end
      5'd1: nxt = t;
      5'd3: begin put(5'd31, npc); nxt = t; end
      5'd4: nxt = vrd;
      5'd2: if (vrd != a) nxt = npc + imm;
      5'd6: if ($signed(vrd) < $signed(a)) nxt = npc + imm;
      5'd21: put(5'd30, t);
      5'd22: if (ref_regs[30] != 32'd0) nxt = t;
      default: ;
    endcase
    if (e_we) ref_regs[e_wr] = e_wd;
    ref_pc = nxt;
  endtask

  // Called at a negedge in FETCH; returns at the negedge of the following FETCH.
  task automatic step();
    logic [31:0] pc0;
    logic        ex_we;
    pc0 = ref_pc;
    model_step();
    ex_we = e_we && !e_lw;
    chk("fetch_pc", address_imem, pc0);
    chk("fetch_we", {31'b0, ctrl_writeEnable}, 32'd0);
    chk("fetch_wren", {31'b0, wren}, 32'd0);
    @(negedge clock);
    chk("exec_pc", address_imem, pc0);
    chk("exec_wren", {31'b0, wren}, {31'b0, e_wren});
    if (e_wren) begin
      chk("sw_addr", {20'b0, address_dmem[11:0]}, {20'b0, e_maddr});
      chk("sw_data", data, e_mdata);
    end
    chk("exec_we", {31'b0, ctrl_writeEnable}, {31'b0, ex_we});
    if (ex_we) begin
      chk("exec_wreg", {27'b0, ctrl_writeReg}, {27'b0, e_wr});
      chk("exec_wdata", data_writeReg, e_wd);
    end
    @(negedge clock);
    if (e_lw) begin
      chk("mem_pc", address_imem, pc0);
      chk("mem_wren", {31'b0, wren}, 32'd0);
      chk("mem_we", {31'b0, ctrl_writeEnable}, {31'b0, e_we});
      if (e_we) begin
        chk("mem_wreg", {27'b0, ctrl_writeReg}, {27'b0, e_wr});
        chk("mem_wdata", data_writeReg, e_wd);
      end
      @(negedge clock);
    end
  endtask

  task automatic start();
    reset   = 1'b0;
    load_en = 1'b1;
    @(posedge clock);
    #1 load_en = 1'b0;
    chk("rst_pc", address_imem, 32'd0);
    chk("rst_we", {31'b0, ctrl_writeEnable}, 32'd0);
    chk("rst_wren", {31'b0, wren}, 32'd0);
    @(negedge clock);
    reset  = 1'b1;
    ref_pc = 32'd0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
  endtask

  task automatic check_state();
    for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), hw_regs[i], ref_regs[i]);
    for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) chk($sformatf("ram%0d", i), ram[i], ref_mem[i]);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] fn, rd, rs, rt, sh);
    return {5'd0, rd, rs, rt, sh, fn, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, rd, rs, v[16:0]};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input int t);
    logic [31:0] v;
    v = t;
    return {op, v[26:0]};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'h7fff_ffff;
      1: return 32'h8000_0000;
      2: return $urandom_range(0, 15);
      3: return -$urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs, rt, sh;
    int         si, tg;
    rd = 5'($urandom_range(0, 31));
    rs = 5'($urandom_range(0, 31));
    rt = 5'($urandom_range(0, 31));
    sh = 5'($urandom_range(0, 31));
    si = $urandom_range(0, 16) - 8;
    tg = $urandom_range(0, 63);
    case ($urandom_range(0, 15))
      0, 1, 2, 3: return enc_r(5'($urandom_range(0, 7)), rd, rs, rt, sh);
      4:  return enc_i(5'd5, rd, rs, $urandom_range(0, 131071));
      5:  return enc_i(5'd7, rd, rs, $urandom_range(0, 131071));
      6:  return enc_i(5'd8, rd, rs, $urandom_range(0, 131071));
      7:  return enc_j(5'd1, tg);
      8:  return enc_j(5'd3, tg);
      9:  return enc_i(5'd4, rd, rs, si);
      10: return enc_i(5'd2, rd, rs, si);
      11: return enc_i(5'd6, rd, rs, si);
      12: return enc_j(5'd21, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 1000)));
      13: return enc_j(5'd22, tg);
      14: return $urandom;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    // Arithmetic, store and load.
    clear_all();
    rom[0] = enc_i(5'd5, 5'd1, 5'd0, 5);
    rom[1] = enc_i(5'd5, 5'd2, 5'd0, 7);
    rom[2] = enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
    rom[3] = enc_r(5'd1, 5'd4, 5'd1, 5'd2, 5'd0);
    rom[4] = enc_i(5'd7, 5'd3, 5'd0, 0);
    rom[5] = enc_i(5'd8, 5'd5, 5'd0, 0);
    start();
    repeat (6) step();
    chk("A_ref_r3", ref_regs[3], 32'd12);
    chk("A_ref_r4", ref_regs[4], 32'hffff_fffe);
    chk("A_ref_r5", ref_regs[5], 32'd12);
    chk("A_ram0", ram[0], 32'd12);
    check_state();

    // Reset during EXEC of the second addi.
    clear_all();
    rom[0] = enc_i(5'd5, 5'd1, 5'd0, 5);
    rom[1] = enc_i(5'd5, 5'd2, 5'd0, 7);
    start();
    step();
    @(negedge clock);
    chk("pre_rst_we", {31'b0, ctrl_writeEnable}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_we", {31'b0, ctrl_writeEnable}, 32'd0);
    chk("midrst_pc", address_imem, 32'd0);
    @(posedge clock);
    #1 chk("midrst_nowrite", hw_regs[2], 32'd0);
    @(negedge clock);
    reset  = 1'b1;
    ref_pc = 32'd0;
    repeat (2) step();
    chk("rst_r2", hw_regs[2], 32'd7);
    check_state();

    // Overflow redirection to r30.
    clear_all();
    rom[0] = enc_i(5'd5, 5'd1, 5'd0, 1);
    rom[1] = enc_r(5'd4, 5'd2, 5'd1, 5'd0, 5'd31);
    rom[2] = enc_r(5'd1, 5'd3, 5'd2, 5'd1, 5'd0);
    rom[3] = enc_j(5'd21, 27'h7ff_ffff);
    rom[4] = enc_r(5'd4, 5'd6, 5'd30, 5'd0, 5'd4);
    rom[5] = enc_i(5'd5, 5'd6, 5'd6, 15);
    rom[6] = enc_i(5'd5, 5'd8, 5'd6, 1);
    start();
    repeat (3) step();
    chk("B_r2", hw_regs[2], 32'h8000_0000);
    chk("B_sub_ovf_r30", hw_regs[30], 32'd3);
    chk("B_r3_kept", hw_regs[3], 32'd0);
    repeat (4) step();
    chk("B_r6", ref_regs[6], 32'h7fff_ffff);
    chk("B_addi_ovf_r30", hw_regs[30], 32'd2);
    check_state();

    // Branches, jumps, setx/bex.
    clear_all();
    rom[0]  = enc_i(5'd5, 5'd1, 5'd0, 1);
    rom[1]  = enc_i(5'd5, 5'd2, 5'd0, 2);
    rom[2]  = enc_i(5'd2, 5'd1, 5'd2, 2);
    rom[3]  = enc_i(5'd5, 5'd9, 5'd0, 99);
    rom[4]  = enc_i(5'd5, 5'd9, 5'd0, 99);
    rom[5]  = enc_i(5'd6, 5'd2, 5'd1, 3);
    rom[6]  = enc_j(5'd3, 10);
    rom[7]  = enc_j(5'd21, 7);
    rom[8]  = enc_j(5'd22, 20);
    rom[10] = enc_i(5'd4, 5'd31, 5'd0, 0);
    rom[20] = enc_j(5'd21, 0);
    rom[21] = enc_j(5'd22, 5);
    rom[22] = enc_i(5'd5, 5'd10, 5'd0, 3);
    start();
    repeat (5) step();
    chk("C_jal_target", address_imem, 32'd10);
    chk("C_jal_r31", hw_regs[31], 32'd7);
    repeat (3) step();
    chk("C_bex_target", address_imem, 32'd20);
    repeat (3) step();
    chk("C_fallthrough_pc", address_imem, 32'd23);
    chk("C_skipped_r9", ref_regs[9], 32'd0);
    chk("C_r10", ref_regs[10], 32'd3);
    check_state();

    // Randomized programs.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) rom[i] = rand_instr();
      ref_regs[0] = 32'd0;
      for (int i = 1; i < 32; i++) ref_regs[i] = pick_val();
      for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
      start();
      repeat (300) step();
      check_state();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
